// File: rtl/registerfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits, write-through
// bypass on both read ports, and a one-register-per-cycle clear sweep.

module registerfile_scoreboard_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic             setEn,
  input  logic             clrEn,
  input  logic [WIDTH-1:0] wData,
  output logic [WIDTH-1:0] q,
  output logic             pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      pend <= 1'b0;
    end else if (clrEn) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (wrEn) q <= wData;
      // A same-cycle load issue outranks the retiring write.
      if (setEn)     pend <= 1'b1;
      else if (wrEn) pend <= 1'b0;
    end
  end

endmodule

module registerfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] Ra,
  input  logic [AWIDTH-1:0] Rb,
  output logic [WIDTH-1:0]  Ba,
  output logic [WIDTH-1:0]  Bb,
  input  logic [AWIDTH-1:0] Rw,
  input  logic [WIDTH-1:0]  Bw,
  input  logic              Regwr,
  input  logic [AWIDTH-1:0] Rp,
  input  logic              Setp,
  output logic              Pa,
  output logic              Pb,
  input  logic              Clr,
  output logic              Busy
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST = {AWIDTH{1'b1}};

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]                   state;
  logic [AWIDTH-1:0]            idx;
  logic [DEPTH-1:0][WIDTH-1:0]  regQ;
  logic [DEPTH-1:0]             pendQ;
  logic                         busy;
  logic                         wrOk;
  logic                         setOk;

  assign busy  = (state == CLEAR);
  assign Busy  = busy;
  assign wrOk  = Regwr && !busy && (Rw != '0);
  assign setOk = Setp  && !busy && (Rp != '0);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gReg
      if (g == 0) begin : gZero
        assign regQ[g]  = '0;
        assign pendQ[g] = 1'b0;
      end else begin : gCell
        registerfile_scoreboard_cell #(.WIDTH(WIDTH)) uCell (
          .clk   (clk),
          .rst_n (rst_n),
          .wrEn  (wrOk  && (Rw  == AWIDTH'(g))),
          .setEn (setOk && (Rp  == AWIDTH'(g))),
          .clrEn (busy  && (idx == AWIDTH'(g))),
          .wData (Bw),
          .q     (regQ[g]),
          .pend  (pendQ[g])
        );
      end
    end
  endgenerate

  // wrOk already excludes r0, so address 0 never bypasses.
  assign Ba = (wrOk && (Rw == Ra)) ? Bw : regQ[Ra];
  assign Bb = (wrOk && (Rw == Rb)) ? Bw : regQ[Rb];
  assign Pa = pendQ[Ra];
  assign Pb = pendQ[Rb];

  // Sweep runs idx = 1..DEPTH-1 and exits on the last one, so idx never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Clr) begin
            state <= CLEAR;
            idx   <= AWIDTH'(1);
          end
        end
        CLEAR: begin
          if (idx == LAST) state <= IDLE;
          else             idx   <= idx + AWIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_registerfile_scoreboard.sv
// Directed bench for registerfile_scoreboard: default 32x32 instance plus a
// 16-bit x 8-register instance sharing clock and reset.

module tb_registerfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Ra, Rb, Rw, Rp;
  logic [31:0] Ba, Bb, Bw;
  logic        Regwr, Setp, Clr, Pa, Pb, Busy;

  logic [2:0]  sRa, sRb, sRw, sRp;
  logic [15:0] sBa, sBb, sBw;
  logic        sRegwr, sSetp, sClr, sPa, sPb, sBusy;

  int passCnt  = 0;
  int totalCnt = 0;
  int busyCnt;

  always #5 clk = ~clk;

  registerfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .Ra(Ra), .Rb(Rb), .Ba(Ba), .Bb(Bb),
    .Rw(Rw), .Bw(Bw), .Regwr(Regwr), .Rp(Rp), .Setp(Setp),
    .Pa(Pa), .Pb(Pb), .Clr(Clr), .Busy(Busy)
  );

  registerfile_scoreboard #(.WIDTH(16), .AWIDTH(3)) dutSmall (
    .clk(clk), .rst_n(rst_n), .Ra(sRa), .Rb(sRb), .Ba(sBa), .Bb(sBb),
    .Rw(sRw), .Bw(sBw), .Regwr(sRegwr), .Rp(sRp), .Setp(sSetp),
    .Pa(sPa), .Pb(sPb), .Clr(sClr), .Busy(sBusy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    Regwr = 0; Setp = 0; Clr = 0; Rw = 0; Bw = 0; Rp = 0;
  endtask

  task automatic test_reset();
    idle(); Ra = 3; Rb = 4;
    sRa = 0; sRb = 0; sRw = 0; sRp = 0; sBw = 0; sRegwr = 0; sSetp = 0; sClr = 0;
    rst_n = 0;
    #1;
    totalCnt++; if (Ba !== 32'h0) $display("FAIL reset_ba got %h want 0", Ba); else passCnt++;
    totalCnt++; if (Bb !== 32'h0) $display("FAIL reset_bb got %h want 0", Bb); else passCnt++;
    totalCnt++; if ({Pa, Pb, Busy} !== 3'b000) $display("FAIL reset_flags got %b want 000", {Pa, Pb, Busy}); else passCnt++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
  endtask

  task automatic test_r0();
    Regwr = 1; Rw = 0; Bw = 32'h12345678; Ra = 0; Rb = 0;
    #1;
    totalCnt++; if ({Ba, Bb} !== 64'h0) $display("FAIL r0_pre got %h/%h want 0/0", Ba, Bb); else passCnt++;
    tick();
    idle(); Setp = 1; Rp = 0;
    #1;
    totalCnt++; if ({Ba, Bb} !== 64'h0) $display("FAIL r0_post got %h/%h want 0/0", Ba, Bb); else passCnt++;
    tick();
    idle();
    #1;
    totalCnt++; if (Pa !== 1'b0) $display("FAIL r0_pend got %b want 0", Pa); else passCnt++;
  endtask

  task automatic test_write_read();
    for (int i = 1; i < 32; i++) begin
      Regwr = 1; Rw = 5'(i); Bw = 32'(i);
      tick();
    end
    idle(); Ra = 1; Rb = 2;
    #1;
    totalCnt++; if (Ba !== 32'd1) $display("FAIL rd_r1 got %h want 1", Ba); else passCnt++;
    totalCnt++; if (Bb !== 32'd2) $display("FAIL rd_r2 got %h want 2", Bb); else passCnt++;
    Ra = 31;
    #1;
    totalCnt++; if (Ba !== 32'd31) $display("FAIL rd_r31 got %h want 1f", Ba); else passCnt++;
    Ra = 1; Regwr = 1; Rw = 1; Bw = 32'h12345678;
    #1;
    totalCnt++; if (Ba !== 32'h12345678) $display("FAIL bypass_a got %h want 12345678", Ba); else passCnt++;
    totalCnt++; if (Bb !== 32'd2) $display("FAIL bypass_b_other got %h want 2", Bb); else passCnt++;
    tick();
    idle();
    #1;
    totalCnt++; if (Ba !== 32'h12345678) $display("FAIL wr_r1_post got %h want 12345678", Ba); else passCnt++;
  endtask

  task automatic test_pending();
    Setp = 1; Rp = 5; Ra = 5;
    #1;
    totalCnt++; if (Pa !== 1'b0) $display("FAIL pend_nobypass got %b want 0", Pa); else passCnt++;
    tick();
    idle();
    #1;
    totalCnt++; if (Pa !== 1'b1) $display("FAIL pend_set got %b want 1", Pa); else passCnt++;
    Regwr = 1; Rw = 5; Bw = 32'hAA;
    tick();
    idle();
    #1;
    totalCnt++; if ({Pa, Ba} !== {1'b0, 32'hAA}) $display("FAIL pend_wrclr got %b/%h want 0/aa", Pa, Ba); else passCnt++;
    Setp = 1; Rp = 6; Regwr = 1; Rw = 6; Bw = 32'hBB; Ra = 6;
    tick();
    idle(); Setp = 1; Rp = 9; Rb = 9;
    #1;
    totalCnt++; if ({Pa, Ba} !== {1'b1, 32'hBB}) $display("FAIL pend_setwins got %b/%h want 1/bb", Pa, Ba); else passCnt++;
    tick();
    idle();
    #1;
    totalCnt++; if (Pb !== 1'b1) $display("FAIL pend_pb got %b want 1", Pb); else passCnt++;
  endtask

  task automatic test_clear();
    Clr = 1; Regwr = 1; Rw = 3; Bw = 32'h99;
    #1;
    totalCnt++; if (Busy !== 1'b0) $display("FAIL clr_idle_busy got %b want 0", Busy); else passCnt++;
    tick();
    idle(); Ra = 3;
    #1;
    totalCnt++; if ({Busy, Ba} !== {1'b1, 32'h99}) $display("FAIL clr_wr_first got %b/%h want 1/99", Busy, Ba); else passCnt++;
    busyCnt = 0;
    while (Busy === 1'b1 && busyCnt < 100) begin
      busyCnt++;
      idle();
      if (busyCnt == 5) begin Regwr = 1; Rw = 3; Bw = 32'h55; Setp = 1; Rp = 2; Ra = 3; end
      if (busyCnt == 10) begin Clr = 1; Ra = 20; Rb = 4; end
      #1;
      if (busyCnt == 5) begin
        totalCnt++; if (Ba !== 32'h0) $display("FAIL sweep_nobypass got %h want 0", Ba); else passCnt++;
      end
      if (busyCnt == 10) begin
        totalCnt++; if ({Ba, Bb} !== {32'd20, 32'd0}) $display("FAIL sweep_live got %h/%h want 14/0", Ba, Bb); else passCnt++;
      end
      tick();
    end
    idle();
    totalCnt++; if (busyCnt !== 31) $display("FAIL sweep_len got %0d want 31", busyCnt); else passCnt++;
    for (int i = 1; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(i);
      #1;
      totalCnt++;
      if ({Ba, Bb, Pa} !== 65'h0) $display("FAIL sweep_zero r%0d got %h/%b want 0/0", i, Ba, Pa);
      else passCnt++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i++) begin
      Regwr = 1; Rw = 5'(i); Bw = 32'(i);
      tick();
    end
    idle(); Setp = 1; Rp = 4;
    tick();
    idle(); Clr = 1;
    tick();
    idle();
    repeat (9) tick();
    #2;
    rst_n = 0; Ra = 20; Rb = 31;
    #1;
    totalCnt++; if (Busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", Busy); else passCnt++;
    totalCnt++; if ({Ba, Bb} !== 64'h0) $display("FAIL rstmid_rd got %h/%h want 0/0", Ba, Bb); else passCnt++;
    Ra = 4;
    #1;
    totalCnt++; if (Pa !== 1'b0) $display("FAIL rstmid_pend got %b want 0", Pa); else passCnt++;
    #1 rst_n = 1;
    tick();
    totalCnt++; if (Busy !== 1'b0) $display("FAIL rstmid_idle got %b want 0", Busy); else passCnt++;
    Regwr = 1; Rw = 7; Bw = 32'h7;
    tick();
    idle(); Ra = 7; Rb = 8;
    #1;
    totalCnt++; if ({Ba, Bb} !== {32'h7, 32'h0}) $display("FAIL rstmid_wr got %h/%h want 7/0", Ba, Bb); else passCnt++;
  endtask

  task automatic test_small();
    for (int i = 1; i < 8; i++) begin
      sRegwr = 1; sRw = 3'(i); sBw = 16'(i);
      tick();
    end
    sRegwr = 0; sRa = 1; sRb = 2;
    #1;
    totalCnt++; if ({sBa, sBb} !== {16'd1, 16'd2}) $display("FAIL small_rd got %h/%h want 1/2", sBa, sBb); else passCnt++;
    sRa = 7;
    #1;
    totalCnt++; if (sBa !== 16'd7) $display("FAIL small_r7 got %h want 7", sBa); else passCnt++;
    sRa = 1; sRegwr = 1; sRw = 1; sBw = 16'h1234;
    #1;
    totalCnt++; if (sBa !== 16'h1234) $display("FAIL small_bypass got %h want 1234", sBa); else passCnt++;
    tick();
    sRegwr = 0;
    #1;
    totalCnt++; if (sBa !== 16'h1234) $display("FAIL small_wr got %h want 1234", sBa); else passCnt++;
    sClr = 1;
    tick();
    sClr = 0;
    busyCnt = 0;
    while (sBusy === 1'b1 && busyCnt < 100) begin
      busyCnt++;
      tick();
    end
    totalCnt++; if (busyCnt !== 7) $display("FAIL small_sweep_len got %0d want 7", busyCnt); else passCnt++;
    for (int i = 1; i < 8; i++) begin
      sRa = 3'(i);
      #1;
      totalCnt++; if (sBa !== 16'h0) $display("FAIL small_zero r%0d got %h want 0", i, sBa); else passCnt++;
    end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_write_read();
    test_pending();
    test_clear();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
